apb_master_ctrl: RTL

Downstream consumer of the bridge's write-posting FIFO. Pops buffered AHB write entries (address, data, size) and issues each as one APB write transfer (SETUP → ACCESS), deriving byte strobes from size and address and honouring PREADY wait states and PSLVERR. It also reports errors to the AHB side through a pulse and a saturating counter. An optional watchdog aborts transfers stalled by a non-responding slave.

---
 rtl/apb_master_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - drains the write-posting FIFO into APB write transfers
// Optional watchdog: define APB_TIMEOUT_EN to abort ACCESS phases stalled by a silent slave.
module apb_master_ctrl #(
    parameter int AHB_AW         = 32,
    parameter int AHB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AHB_AW-1:0]     i_haddr,
    input  logic [AHB_DW-1:0]     i_hwdata,
    input  logic [2:0]            i_hsize,
    input  logic                  i_fifo_empty,
    output logic                  o_read,
    output logic [AHB_AW-1:0]     o_paddr,
    output logic [AHB_DW-1:0]     o_pwdata,
    output logic [AHB_DW/8-1:0]   o_pstrb,
    output logic                  o_pwrite,
    output logic                  o_psel,
    output logic                  o_penable,
    input  logic                  i_pready,
    input  logic                  i_pslverr,
    output logic                  o_err,
    output logic                  o_timeout,
    output logic [7:0]            o_err_cnt,
    output logic                  o_busy
);

    localparam int SW = AHB_DW / 8;
    localparam int LW = $clog2(SW);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [AHB_AW-1:0]  paddr_q;
    logic [AHB_DW-1:0]  pwdata_q;
    logic [SW-1:0]      pstrb_q;
    logic               err_q;
    logic               timeout_q;
    logic [7:0]         err_cnt_q;
    logic               abort;
    logic               done;
    logic               xfer_err;
    logic               read;

    // Byte lanes covered by an access of 2^size bytes, aligned down to its natural boundary;
    // sizes wider than the bus light every lane.
    function automatic logic [SW-1:0] strobe_of(input logic [AHB_AW-1:0] addr,
                                                input logic [2:0] size);
        int n;
        int off;
        logic [SW-1:0] s;
        n   = (int'(size) > LW) ? LW : int'(size);
        off = int'(addr & AHB_AW'(SW - 1));
        off = (off >> n) << n;
        s   = '0;
        for (int i = 0; i < SW; i++) begin
            s[i] = (i >= off) && (i < off + (1 << n));
        end
        return s;
    endfunction

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] wd_cnt;

    // A stalled ACCESS aborts on its TIMEOUT_CYCLES-th cycle unless PREADY shows up then.
    assign abort = (state == ACCESS) && !i_pready && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counts wait cycles of the current ACCESS phase; any other state clears it.
    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) begin
            wd_cnt <= '0;
        end else if (!i_pready) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign abort              = 1'b0;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
`endif

    assign done     = (state == ACCESS) && (i_pready || abort);
    assign xfer_err = i_pready ? i_pslverr : abort;
    assign read     = !rst && !i_fifo_empty && ((state == IDLE) || done);

    // Next-state: pop from IDLE or straight out of a completing ACCESS for back-to-back writes.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (read) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (done) state_nx = read ? SETUP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // APB address/data/strobe are captured on the pop and held for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (read) begin
            paddr_q  <= i_haddr;
            pwdata_q <= i_hwdata;
            pstrb_q  <= strobe_of(i_haddr, i_hsize);
        end
    end

    // Error reporting: one-cycle pulses after the completing cycle, saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= done && xfer_err;
            timeout_q <= abort;
            if (done && xfer_err && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign o_read    = read;
    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;
    assign o_pstrb   = pstrb_q;
    assign o_pwrite  = 1'b1;
    assign o_psel    = (state != IDLE);
    assign o_penable = (state == ACCESS);
    assign o_busy    = (state != IDLE);
    assign o_err     = err_q;
    assign o_timeout = timeout_q;
    assign o_err_cnt = err_cnt_q;

endmodule
